// File: rtl/riscv_pkg.sv
// Shared core types: XLEN, fetch FSM states, NOP fill word and the queue entry layout.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FQ_IDLE,
      FQ_RUN,
      FQ_FULL
   } fq_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular entry store for the fetch queue: ISSUE_W writes at tail, ISSUE_W reads at head.
module fq_ring #(
   parameter int XLEN    = 32,
   parameter int ISSUE_W = 2,
   parameter int DEPTH   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         wr_en,
   input  logic [ISSUE_W*XLEN-1:0]      wr_pc,
   input  logic [ISSUE_W*XLEN-1:0]      wr_instr,
   input  logic [$clog2(DEPTH+1)-1:0]   rd_adv,
   output logic [ISSUE_W*XLEN-1:0]      rd_pc,
   output logic [ISSUE_W*XLEN-1:0]      rd_instr
);
   import riscv_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [XLEN-1:0]  instr_mem [DEPTH];

   // DEPTH is a power of two, so dropping the carry is the modulo.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int off);
      return ptr + PTR_W'(off);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (wr_en) begin
            tail <= ptr_add(tail, ISSUE_W);
         end
         head <= ptr_add(head, int'(rd_adv));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < ISSUE_W; k++) begin
            pc_mem[ptr_add(tail, k)]    <= wr_pc[k*XLEN +: XLEN];
            instr_mem[ptr_add(tail, k)] <= wr_instr[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rd_pc    = '0;
      rd_instr = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         rd_pc[k*XLEN +: XLEN]    = pc_mem[ptr_add(head, k)];
         rd_instr[k*XLEN +: XLEN] = instr_mem[ptr_add(head, k)];
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Superscalar fetch front end: fetches ISSUE_W words per cycle into fq_ring, issues with variable take.
// Define FETCH_QUEUE_STATS_EN to build the stall/flush statistics counters.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              ISSUE_W  = 2,
   parameter int              DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_en,
   output logic [XLEN-1:0]                imem_addr,
   input  logic [ISSUE_W*XLEN-1:0]        imem_rdata,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   output logic [ISSUE_W-1:0]             issue_valid,
   output logic [ISSUE_W*XLEN-1:0]        issue_instr,
   output logic [ISSUE_W*XLEN-1:0]        issue_pc,
   input  logic [$clog2(ISSUE_W+1)-1:0]   issue_take,
   output logic [$clog2(DEPTH+1)-1:0]     fq_count,
   output logic [31:0]                    fetch_stall_cnt,
   output logic [31:0]                    flush_cnt
);
   import riscv_pkg::*;

   localparam int              CNT_W       = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ISSUE_C    = CNT_W'(ISSUE_W);
   localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(4*ISSUE_W);
   localparam logic [XLEN-1:0] RESET_ALGN  = RESET_PC & ~(XLEN'(3));

   fq_state_t              state;
   fq_state_t              state_next;
   logic [XLEN-1:0]        fetch_pc;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       count_next;
   logic [CNT_W-1:0]       free_now;
   logic [CNT_W-1:0]       free_next;
   logic [CNT_W-1:0]       take_eff;
   logic                   do_fetch;
   logic [ISSUE_W*XLEN-1:0] wr_pc;
   logic [ISSUE_W*XLEN-1:0] rd_pc;
   logic [ISSUE_W*XLEN-1:0] rd_instr;

   assign imem_addr = {fetch_pc[XLEN-1:2], 2'b00};
   assign fq_count  = count;
   assign free_now  = DEPTH_C - count;
   assign take_eff  = (CNT_W'(issue_take) > count) ? count : CNT_W'(issue_take);

   // Only start-of-cycle free space counts; slots freed by this cycle's take are not reused.
   assign do_fetch = (state == FQ_RUN) && fetch_en && !redirect_valid && (free_now >= ISSUE_C);

   always_comb begin
      count_next = count;
      if (redirect_valid) begin
         count_next = '0;
      end else begin
         count_next = count + (do_fetch ? ISSUE_C : '0) - take_eff;
      end
   end

   assign free_next = DEPTH_C - count_next;

   always_comb begin
      state_next = state;
      case (state)
         FQ_IDLE: if (fetch_en) state_next = FQ_RUN;
         FQ_RUN: begin
            if (!fetch_en)                  state_next = FQ_IDLE;
            else if (free_next < ISSUE_C)   state_next = FQ_FULL;
         end
         FQ_FULL: begin
            if (!fetch_en)                  state_next = FQ_IDLE;
            else if (free_next >= ISSUE_C)  state_next = FQ_RUN;
         end
         default: state_next = FQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FQ_IDLE;
         count    <= '0;
         fetch_pc <= RESET_ALGN;
      end else begin
         state <= state_next;
         count <= count_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~(XLEN'(3));
         end else if (do_fetch) begin
            fetch_pc <= fetch_pc + GROUP_BYTES;
         end
      end
   end

   always_comb begin
      wr_pc = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         wr_pc[k*XLEN +: XLEN] = imem_addr + XLEN'(4*k);
      end
   end

   fq_ring #(
      .XLEN    (XLEN),
      .ISSUE_W (ISSUE_W),
      .DEPTH   (DEPTH)
   ) u_ring (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .wr_en    (do_fetch),
      .wr_pc    (wr_pc),
      .wr_instr (imem_rdata),
      .rd_adv   (take_eff),
      .rd_pc    (rd_pc),
      .rd_instr (rd_instr)
   );

   // Slots beyond the occupancy show a NOP so stale ring contents never leak to decode.
   always_comb begin
      issue_valid = '0;
      issue_instr = '0;
      issue_pc    = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         if (CNT_W'(k) < count) begin
            issue_valid[k]             = 1'b1;
            issue_pc[k*XLEN +: XLEN]    = rd_pc[k*XLEN +: XLEN];
            issue_instr[k*XLEN +: XLEN] = rd_instr[k*XLEN +: XLEN];
         end else begin
            issue_instr[k*XLEN +: XLEN] = XLEN'(NOP);
         end
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   logic        stall;
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign stall = fetch_en && !redirect_valid && (free_now < ISSUE_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall)          stall_q <= sat_inc(stall_q);
         if (redirect_valid) flush_q <= sat_inc(flush_q);
      end
   end

   assign fetch_stall_cnt = stall_q;
   assign flush_cnt       = flush_q;
`else
   assign fetch_stall_cnt = '0;
   assign flush_cnt       = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order PC scoreboard on the issue side plus occupancy/address checks.
module tb_fetch_queue;

   localparam int XLEN    = 32;
   localparam int ISSUE_W = 2;
   localparam int DEPTH   = 8;

`ifdef FETCH_QUEUE_STATS_EN
   localparam logic [31:0] EXP_STALL = 32'd3;
   localparam logic [31:0] EXP_FLUSH = 32'd3;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

   logic                         clk;
   logic                         reset;
   logic                         fetch_en;
   logic [XLEN-1:0]              imem_addr;
   logic [ISSUE_W*XLEN-1:0]      imem_rdata;
   logic                         redirect_valid;
   logic [XLEN-1:0]              redirect_pc;
   logic [ISSUE_W-1:0]           issue_valid;
   logic [ISSUE_W*XLEN-1:0]      issue_instr;
   logic [ISSUE_W*XLEN-1:0]      issue_pc;
   logic [$clog2(ISSUE_W+1)-1:0] issue_take;
   logic [$clog2(DEPTH+1)-1:0]   fq_count;
   logic [31:0]                  fetch_stall_cnt;
   logic [31:0]                  flush_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   fetch_queue #(
      .XLEN     (XLEN),
      .ISSUE_W  (ISSUE_W),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_en        (fetch_en),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .issue_valid     (issue_valid),
      .issue_instr     (issue_instr),
      .issue_pc        (issue_pc),
      .issue_take      (issue_take),
      .fq_count        (fq_count),
      .fetch_stall_cnt (fetch_stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   // Instruction memory: the word at address a reads as 0x100 + a.
   always_comb begin
      imem_rdata = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         imem_rdata[k*XLEN +: XLEN] = imem_addr + 32'h100 + 32'(4*k);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic [31:0] base, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4*i));
   endtask

   // Monitor: every slot consumed at the coming edge must be the next expected PC.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset && !redirect_valid) begin
         for (int k = 0; k < ISSUE_W; k++) begin
            if (k < int'(issue_take) && issue_valid[k]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL issue_unexpected: got pc %h expected none", issue_pc[k*XLEN +: XLEN]);
               end else begin
                  e = exp_q.pop_front();
                  check("issue_pc_seq", issue_pc[k*XLEN +: XLEN], e);
                  check("issue_instr_seq", issue_instr[k*XLEN +: XLEN], e + 32'h100);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clk            = 1'b0;
      reset          = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      issue_take     = '0;

      #12;
      check("rst_issue_valid", 32'(issue_valid), 32'd0);
      check("rst_fq_count", 32'(fq_count), 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_stall_cnt", fetch_stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      step();
      reset = 1'b1;

      // Fill from reset with no take
      push_stream(32'h0, 64);
      fetch_en = 1'b1;
      step();
      check("t1_addr_c1", imem_addr, 32'h0);
      check("t1_count_c1", 32'(fq_count), 32'd0);
      step();
      check("t1_addr_c2", imem_addr, 32'h8);
      check("t1_count_c2", 32'(fq_count), 32'd2);
      check("t1_valid_c2", 32'(issue_valid), 32'h3);
      step();
      step();
      step();
      check("t1_count_full", 32'(fq_count), 32'd8);
      check("t1_addr_full", imem_addr, 32'h20);
      step();
      check("t1_count_hold", 32'(fq_count), 32'd8);
      check("t1_addr_hold", imem_addr, 32'h20);

      // Drain two per cycle from a full queue
      issue_take = 2'd2;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t2_count", 32'(fq_count), 32'd6);
      end
      check("t2_addr", imem_addr, 32'h68);

      // Bring count to 5, then redirect with a take in the same cycle
      fetch_en   = 1'b0;
      issue_take = 2'd1;
      step();
      check("t3_count_pre", 32'(fq_count), 32'd5);
      fetch_en       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      issue_take     = 2'd2;
      push_stream(32'h200, 64);
      step();
      check("t3_count_flush", 32'(fq_count), 32'd0);
      check("t3_addr_flush", imem_addr, 32'h200);
      redirect_valid = 1'b0;
      issue_take     = 2'd0;
      step();
      check("t3_pc0", issue_pc[0 +: XLEN], 32'h200);
      check("t3_pc1", issue_pc[XLEN +: XLEN], 32'h204);
      check("t3_instr1", issue_instr[XLEN +: XLEN], 32'h304);
      check("t3_valid", 32'(issue_valid), 32'h3);

      // Over-take is clamped to occupancy
      fetch_en   = 1'b0;
      issue_take = 2'd1;
      step();
      check("t4_count1", 32'(fq_count), 32'd1);
      check("t4_valid1", 32'(issue_valid), 32'h1);
      issue_take = 2'd2;
      step();
      check("t4_count0", 32'(fq_count), 32'd0);
      check("t4_valid0", 32'(issue_valid), 32'h0);
      step();
      check("t4_count_empty", 32'(fq_count), 32'd0);
      check("t4_addr", imem_addr, 32'h208);

      // Take one per cycle while fetching two: pointers wrap repeatedly
      fetch_en   = 1'b1;
      issue_take = 2'd1;
      repeat (40) step();
      check("t5_count", 32'(fq_count), 32'd6);
      check("t5_addr", imem_addr, 32'h2B8);

      // Asynchronous reset mid-stream
      #2;
      reset = 1'b0;
      #1;
      check("t6_valid_async", 32'(issue_valid), 32'd0);
      check("t6_addr_async", imem_addr, 32'h0);
      check("t6_count_async", 32'(fq_count), 32'd0);
      step();
      issue_take = 2'd0;
      push_stream(32'h0, 64);
      reset = 1'b1;

      // Fill then stall three cycles, then three redirects
      repeat (8) step();
      check("t6_stall_cnt", fetch_stall_cnt, EXP_STALL);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      push_stream(32'h400, 64);
      repeat (3) step();
      redirect_valid = 1'b0;
      check("t6_flush_cnt", flush_cnt, EXP_FLUSH);
      check("t6_stall_after_flush", fetch_stall_cnt, EXP_STALL);
      step();
      check("t6_addr_restart", imem_addr, 32'h408);
      check("t6_count_restart", 32'(fq_count), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
